// File: rtl/dmem_responder_if.sv
`default_nettype none
// ============================================================================
//  Module   : dmem_responder_if
//  Purpose  : Request/response bundle between the memory stage (master) and
//             the data-memory responder (slave).
//  Signals  : req_i     request valid from memory stage
//             we_i      1 = store, 0 = load
//             addr_i    byte address
//             wdata_i   store data, right-aligned
//             funct3_i  RV32I load/store funct3
//             ready_o   responder idle, request accepted this cycle if req_i=1
//             ack_o     one-cycle response strobe
//             rdata_o   load result, valid while ack_o=1
//             err_o     access fault, valid while ack_o=1
//  Revision : 1.0 - initial release
// ============================================================================
interface dmem_responder_if;
   logic        req_i;
   logic        we_i;
   logic [31:0] addr_i;
   logic [31:0] wdata_i;
   logic [2:0]  funct3_i;
   logic        ready_o;
   logic        ack_o;
   logic [31:0] rdata_o;
   logic        err_o;

   modport master (
      output req_i, we_i, addr_i, wdata_i, funct3_i,
      input  ready_o, ack_o, rdata_o, err_o
   );

   modport slave (
      input  req_i, we_i, addr_i, wdata_i, funct3_i,
      output ready_o, ack_o, rdata_o, err_o
   );
endinterface
`default_nettype wire

// File: rtl/dmem_responder.sv
`default_nettype none
// ============================================================================
//  Module   : dmem_responder
//  Purpose  : Data-memory target for the RV32I memory stage. Accepts one
//             load/store at a time, waits WAIT_STATES cycles, then returns a
//             one-cycle acknowledge carrying read data or a fault flag.
//             Byte/halfword/word steering and extension follow funct3.
//  Ports    : clk_i  clock, rising edge
//             rst_i  asynchronous active-low reset
//             bus    dmem_responder_if.slave request/response bundle
//  Revision : 1.0 - initial release
// ============================================================================
module dmem_responder #(
   parameter int unsigned DEPTH_WORDS = 256,
   parameter int unsigned WAIT_STATES = 2,
   parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
   input  wire logic        clk_i,
   input  wire logic        rst_i,
   dmem_responder_if.slave  bus
);

   localparam int unsigned c_AW    = $clog2(DEPTH_WORDS);
   localparam logic [31:0] c_BYTES = 32'(DEPTH_WORDS * 4);
   localparam logic [3:0]  c_WAIT  = 4'(WAIT_STATES);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_WAIT = 2'd1,
      S_RESP = 2'd2
   } state_t;

   state_t            r_state;
   state_t            w_state_nxt;
   logic [3:0]        r_cnt;
   logic [3:0]        w_cnt_nxt;
   logic              w_enter_resp;

   logic              r_we;
   logic [31:0]       r_addr;
   logic [31:0]       r_wdata;
   logic [2:0]        r_funct3;
   logic [31:0]       r_rdata;
   logic              r_err;

   logic [31:0]       r_mem [DEPTH_WORDS];

   logic              w_accept;
   logic              w_src_we;
   logic [31:0]       w_src_addr;
   logic [31:0]       w_src_wdata;
   logic [2:0]        w_src_funct3;
   logic [31:0]       w_off;
   logic [c_AW-1:0]   w_idx;
   logic [1:0]        w_lane;
   logic              w_range_err;
   logic              w_f3_err;
   logic              w_align_err;
   logic              w_fault;
   logic [31:0]       w_word;
   logic [7:0]        w_byte;
   logic [15:0]       w_half;
   logic [31:0]       w_load;
   logic [3:0]        w_wmask;
   logic [31:0]       w_wdata_al;
   logic [31:0]       w_merged;
   logic              w_write;

   assign w_accept = (r_state == S_IDLE) && bus.req_i;

   // ---------------------------------------------------------------------
   // FSM: state register
   // ---------------------------------------------------------------------
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         r_state <= S_IDLE;
         r_cnt   <= 4'd0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
      end
   end

   // ---------------------------------------------------------------------
   // FSM: next state. w_enter_resp marks the edge on which storage is
   // written and the response registers are loaded.
   // ---------------------------------------------------------------------
   always_comb begin
      w_state_nxt  = r_state;
      w_cnt_nxt    = r_cnt;
      w_enter_resp = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (bus.req_i) begin
               if (c_WAIT == 4'd0) begin
                  w_state_nxt  = S_RESP;
                  w_enter_resp = 1'b1;
               end else begin
                  w_state_nxt = S_WAIT;
                  w_cnt_nxt   = c_WAIT;
               end
            end
         end
         S_WAIT: begin
            w_cnt_nxt = r_cnt - 4'd1;
            if (r_cnt == 4'd1) begin
               w_state_nxt  = S_RESP;
               w_enter_resp = 1'b1;
            end
         end
         S_RESP:  w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // With zero wait states the response edge is the accept edge itself, so
   // the request is taken straight from the bus while idle and from the
   // latched copy otherwise.
   assign w_src_we     = (r_state == S_IDLE) ? bus.we_i     : r_we;
   assign w_src_addr   = (r_state == S_IDLE) ? bus.addr_i   : r_addr;
   assign w_src_wdata  = (r_state == S_IDLE) ? bus.wdata_i  : r_wdata;
   assign w_src_funct3 = (r_state == S_IDLE) ? bus.funct3_i : r_funct3;

   // ---------------------------------------------------------------------
   // Address decode and fault detection
   // ---------------------------------------------------------------------
   assign w_off       = w_src_addr - BASE_ADDR;
   assign w_idx       = w_off[c_AW+1:2];
   assign w_lane      = w_src_addr[1:0];
   assign w_range_err = (w_off >= c_BYTES);

   always_comb begin
      w_f3_err = 1'b0;
      if (w_src_we) begin
         w_f3_err = (w_src_funct3 > 3'd2);
      end else begin
         w_f3_err = (w_src_funct3 == 3'd3) || (w_src_funct3 == 3'd6) ||
                    (w_src_funct3 == 3'd7);
      end
   end

   // funct3[1:0] = 01 covers LH/LHU/SH, 10 covers LW/SW
   assign w_align_err = ((w_src_funct3[1:0] == 2'b01) && w_lane[0]) ||
                        ((w_src_funct3[1:0] == 2'b10) && (w_lane != 2'b00));
   assign w_fault     = w_range_err || w_f3_err || w_align_err;

   // ---------------------------------------------------------------------
   // Load steering and extension
   // ---------------------------------------------------------------------
   assign w_word = r_mem[w_idx];
   assign w_byte = w_word[{w_lane, 3'b000} +: 8];
   assign w_half = w_word[{w_lane[1], 4'b0000} +: 16];

   always_comb begin
      w_load = w_word;
      case (w_src_funct3)
         3'd0:    w_load = {{24{w_byte[7]}}, w_byte};
         3'd1:    w_load = {{16{w_half[15]}}, w_half};
         3'd4:    w_load = {24'd0, w_byte};
         3'd5:    w_load = {16'd0, w_half};
         default: w_load = w_word;
      endcase
   end

   // ---------------------------------------------------------------------
   // Store lane merge: read-modify-write of the addressed word
   // ---------------------------------------------------------------------
   always_comb begin
      w_wmask    = 4'b1111;
      w_wdata_al = w_src_wdata;
      w_merged   = w_word;
      case (w_src_funct3[1:0])
         2'b00: begin
            w_wmask    = 4'b0001 << w_lane;
            w_wdata_al = {4{w_src_wdata[7:0]}};
         end
         2'b01: begin
            w_wmask    = w_lane[1] ? 4'b1100 : 4'b0011;
            w_wdata_al = {2{w_src_wdata[15:0]}};
         end
         default: ;
      endcase
      for (int b = 0; b < 4; b++) begin
         if (w_wmask[b]) begin
            w_merged[b*8 +: 8] = w_wdata_al[b*8 +: 8];
         end
      end
   end

   // Gated by rst_i so a request presented while reset is held low can
   // never reach storage.
   assign w_write = w_enter_resp && w_src_we && !w_fault && rst_i;

   always_ff @(posedge clk_i) begin
      if (w_write) begin
         r_mem[w_idx] <= w_merged;
      end
   end

   // ---------------------------------------------------------------------
   // Request latch and response registers
   // ---------------------------------------------------------------------
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         r_we     <= 1'b0;
         r_addr   <= 32'd0;
         r_wdata  <= 32'd0;
         r_funct3 <= 3'd0;
         r_rdata  <= 32'd0;
         r_err    <= 1'b0;
      end else begin
         if (w_accept) begin
            r_we     <= bus.we_i;
            r_addr   <= bus.addr_i;
            r_wdata  <= bus.wdata_i;
            r_funct3 <= bus.funct3_i;
         end
         if (w_enter_resp) begin
            r_err   <= w_fault;
            r_rdata <= (w_fault || w_src_we) ? 32'd0 : w_load;
         end
      end
   end

   assign bus.ready_o = (r_state == S_IDLE);
   assign bus.ack_o   = (r_state == S_RESP);
   assign bus.rdata_o = r_rdata;
   assign bus.err_o   = r_err;

endmodule
`default_nettype wire
